fetch_packet_queue: RTL and testbench

FETCH_PACKET_QUEUE -- requirements
Module: fetch_packet_queue

---
 rtl/fetch_packet_queue_pkg.sv | 37 +++
 rtl/fetch_packet_queue_if.sv | 40 ++++
 rtl/fetch_packet_queue_slot_select.sv | 44 ++++
 rtl/fetch_packet_queue.sv | 111 +++++++++++
 tb/tb_fetch_packet_queue.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_packet_queue_pkg.sv
// Shared types and defaults for the fetch packet queue.
// Optional feature macro (see top): FQ_BYPASS_EN.
package fetch_packet_queue_pkg;

  localparam int FQ_DEPTH   = 8;
  localparam int FQ_SLOTS   = 4;
  localparam int FQ_NUM_OUT = 2;

  typedef logic [4:0] FetchID_t;

  typedef enum logic [1:0] {
    IF_FAULT_NONE   = 2'd0,
    IF_ACCESS_FAULT = 2'd1,
    IF_PAGE_FAULT   = 2'd2,
    IF_INTERRUPT    = 2'd3
  } FetchFault_t;

  typedef struct packed {
    FetchID_t                   fetchID;
    logic [30:0]                pc;
    logic [FQ_SLOTS-1:0][31:0]  instr;
    logic [FQ_SLOTS-1:0]        mask;
    FetchFault_t                fault;
  } FetchPacket_t;

  // A faulting packet collapses to one zero pseudo-instruction in slot 0.
  function automatic FetchPacket_t fq_normalize(input FetchPacket_t p);
    FetchPacket_t n;
    n = p;
    if (p.fault != IF_FAULT_NONE) begin
      n.mask  = FQ_SLOTS'(1);
      n.instr = '0;
    end
    return n;
  endfunction

endpackage

// File: rtl/fetch_packet_queue_if.sv
// Fetch-side push bus and decode-side lane bus of the fetch packet queue.
interface fetch_packet_queue_if
  import fetch_packet_queue_pkg::*;
#(
  parameter int DEPTH   = FQ_DEPTH,
  parameter int SLOTS   = FQ_SLOTS,
  parameter int NUM_OUT = FQ_NUM_OUT
) ();

  logic                           IN_valid;
  logic                           OUT_ready;
  FetchID_t                       IN_fetchID;
  logic [30:0]                    IN_pc;
  logic [SLOTS-1:0][31:0]         IN_instr;
  logic [SLOTS-1:0]               IN_mask;
  FetchFault_t                    IN_fault;
  logic                           IN_flush;
  logic                           IN_decReady;
  logic [NUM_OUT-1:0]             OUT_valid;
  logic [NUM_OUT-1:0][31:0]       OUT_instr;
  logic [NUM_OUT-1:0][30:0]       OUT_pc;
  FetchID_t [NUM_OUT-1:0]         OUT_fetchID;
  FetchFault_t [NUM_OUT-1:0]      OUT_fault;
  logic [$clog2(DEPTH+1)-1:0]     OUT_count;

  modport slave (
    input  IN_valid, IN_fetchID, IN_pc, IN_instr, IN_mask, IN_fault,
           IN_flush, IN_decReady,
    output OUT_ready, OUT_valid, OUT_instr, OUT_pc, OUT_fetchID, OUT_fault,
           OUT_count
  );

  modport master (
    output IN_valid, IN_fetchID, IN_pc, IN_instr, IN_mask, IN_fault,
           IN_flush, IN_decReady,
    input  OUT_ready, OUT_valid, OUT_instr, OUT_pc, OUT_fetchID, OUT_fault,
           OUT_count
  );

endinterface

// File: rtl/fetch_packet_queue_slot_select.sv
// Maps the head packet's mask and slot pointer to decode lanes, and reports
// whether set slots remain once every offered lane is consumed.
module fq_slot_select #(
  parameter int SLOTS   = 4,
  parameter int NUM_OUT = 2,
  localparam int SP_W   = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0]              mask,
  input  logic [SP_W-1:0]               sp,
  output logic [NUM_OUT-1:0]            lane_valid,
  output logic [NUM_OUT-1:0][SP_W-1:0]  lane_slot,
  output logic [SP_W-1:0]               next_sp,
  output logic                          remain
);

  logic [SP_W:0] after;
  int            taken;

  // NOTE: every variable gets a default before the loop, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    lane_valid = '0;
    lane_slot  = '0;
    after      = '0;
    remain     = 1'b0;
    taken      = 0;
    for (int s = 0; s < SLOTS; s++) begin
      if (mask[s] && (s >= int'(sp))) begin
        if (taken < NUM_OUT) begin
          lane_valid[taken] = 1'b1;
          lane_slot[taken]  = SP_W'(s);
          after             = (SP_W+1)'(s + 1);
          taken             = taken + 1;
        end else begin
          remain = 1'b1;
        end
      end
    end
  end

  // Only meaningful when remain is set, in which case after < SLOTS.
  assign next_sp = after[SP_W-1:0];

endmodule

// File: rtl/fetch_packet_queue.sv
// Fetch packet queue between fetch and decode; lanes come from the head packet only.
// Define FQ_BYPASS_EN to let a packet pushed into an empty queue reach decode in the same cycle.
module fetch_packet_queue
  import fetch_packet_queue_pkg::*;
#(
  parameter int DEPTH   = FQ_DEPTH,
  parameter int SLOTS   = FQ_SLOTS,
  parameter int NUM_OUT = FQ_NUM_OUT
) (
  input  logic                clk,
  input  logic                rst,
  fetch_packet_queue_if.slave fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int SP_W  = $clog2(SLOTS);

  FetchPacket_t   mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [SP_W-1:0]  sp;

  FetchPacket_t raw_pkt, in_pkt, head_pkt;
  logic ready, drop, push, bypass, head_vld, offer, consume, pop, mem_pop, store;

  logic [NUM_OUT-1:0]           lane_valid;
  logic [NUM_OUT-1:0][SP_W-1:0] lane_slot;
  logic [SP_W-1:0]              next_sp;
  logic                         remain;

  always_comb begin
    raw_pkt = '{fetchID: fq.IN_fetchID, pc: fq.IN_pc, instr: fq.IN_instr,
                mask: fq.IN_mask, fault: fq.IN_fault};
    in_pkt  = fq_normalize(raw_pkt);
  end

  // Ready depends on registered occupancy only; a same-cycle pop never frees a slot.
  assign ready = (count < CNT_W'(DEPTH));
  assign drop  = (in_pkt.mask == '0);
  assign push  = fq.IN_valid && ready && !fq.IN_flush && !drop;

`ifdef FQ_BYPASS_EN
  assign bypass = push && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign head_vld = (count != '0) || bypass;
  assign head_pkt = bypass ? in_pkt : mem[head];

  fq_slot_select #(
    .SLOTS   (SLOTS),
    .NUM_OUT (NUM_OUT)
  ) u_slot_select (
    .mask       (head_pkt.mask),
    .sp         (sp),
    .lane_valid (lane_valid),
    .lane_slot  (lane_slot),
    .next_sp    (next_sp),
    .remain     (remain)
  );

  assign offer   = head_vld && !fq.IN_flush;
  assign consume = offer && fq.IN_decReady;
  assign pop     = consume && !remain;
  // A bypassed packet that is fully consumed never occupies an entry.
  assign mem_pop = pop && !bypass;
  assign store   = push && !(bypass && pop);

  always_comb begin
    fq.OUT_valid   = '0;
    fq.OUT_instr   = '0;
    fq.OUT_pc      = '0;
    fq.OUT_fetchID = '0;
    fq.OUT_fault   = '{default: IF_FAULT_NONE};
    for (int k = 0; k < NUM_OUT; k++) begin
      fq.OUT_valid[k]   = offer && lane_valid[k];
      fq.OUT_instr[k]   = head_pkt.instr[lane_slot[k]];
      fq.OUT_pc[k]      = head_pkt.pc + 31'({lane_slot[k], 1'b0});
      fq.OUT_fetchID[k] = head_pkt.fetchID;
      fq.OUT_fault[k]   = head_pkt.fault;
    end
  end

  assign fq.OUT_ready = ready;
  assign fq.OUT_count = count;

  // NOTE: state registers use non-blocking assignments so every register in
  // this block sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst || fq.IN_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      sp    <= '0;
    end else begin
      if (store)   tail <= tail + 1'b1;
      if (mem_pop) head <= head + 1'b1;
      count <= count + CNT_W'(store) - CNT_W'(mem_pop);
      if (consume) sp <= pop ? '0 : next_sp;
    end
  end

  // NOTE: the payload RAM is not reset; occupancy is tracked by count and
  // the pointers, so a stale entry is never offered.
  always_ff @(posedge clk) begin
    if (store) mem[tail] <= in_pkt;
  end

endmodule

// File: tb/tb_fetch_packet_queue.sv
// Randomized and directed bench for fetch_packet_queue against a queue-of-packets model.
module tb_fetch_packet_queue;
  import fetch_packet_queue_pkg::*;

  localparam int DEPTH   = 8;
  localparam int SLOTS   = 4;
  localparam int NUM_OUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_packet_queue_if #(.DEPTH(DEPTH), .SLOTS(SLOTS), .NUM_OUT(NUM_OUT)) bus ();

  fetch_packet_queue #(.DEPTH(DEPTH), .SLOTS(SLOTS), .NUM_OUT(NUM_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: stored packets in order, plus the list of slots still owed from the head.
  FetchPacket_t mq[$];
  int           head_rem[$];
  bit           head_loaded = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [30:0] pc, input logic [3:0] mask,
                       input logic [1:0] fault, input bit flush, input bit dec);
    bus.IN_valid    = v;
    bus.IN_pc       = pc;
    bus.IN_mask     = mask;
    bus.IN_fault    = FetchFault_t'(fault);
    bus.IN_flush    = flush;
    bus.IN_decReady = dec;
    bus.IN_fetchID  = FetchID_t'($urandom);
    for (int s = 0; s < SLOTS; s++) bus.IN_instr[s] = $urandom;
  endtask

  function automatic FetchPacket_t model_pkt();
    FetchPacket_t p;
    p.fetchID = bus.IN_fetchID;
    p.pc      = bus.IN_pc;
    p.instr   = bus.IN_instr;
    p.mask    = bus.IN_mask;
    p.fault   = bus.IN_fault;
    if (bus.IN_fault != IF_FAULT_NONE) begin
      p.mask  = 4'b0001;
      p.instr = '0;
    end
    return p;
  endfunction

  // One clock: compare outputs on the falling edge, then advance the model at the rising edge.
  task automatic step();
    FetchPacket_t np, hp;
    int rem[$];
    bit have, push, byp, drop;
    int n;
    logic [NUM_OUT-1:0] exp_valid;
    @(negedge clk);
    np   = model_pkt();
    drop = (bus.IN_mask == '0) && (bus.IN_fault == IF_FAULT_NONE);
    push = bus.IN_valid && (mq.size() < DEPTH) && !bus.IN_flush && !drop;
    byp  = 1'b0;
`ifdef FQ_BYPASS_EN
    byp  = push && (mq.size() == 0);
`endif
    have = 1'b0;
    hp   = '0;
    rem.delete();
    if (mq.size() > 0) begin
      hp = mq[0]; rem = head_rem; have = 1'b1;
    end else if (byp) begin
      hp = np; have = 1'b1;
      for (int s = 0; s < SLOTS; s++) if (np.mask[s]) rem.push_back(s);
    end
    n = (have && !bus.IN_flush) ? ((rem.size() < NUM_OUT) ? rem.size() : NUM_OUT) : 0;
    exp_valid = '0;
    for (int k = 0; k < n; k++) exp_valid[k] = 1'b1;
    check("ready", bus.OUT_ready, mq.size() < DEPTH);
    check("count", bus.OUT_count, mq.size());
    check("valid", bus.OUT_valid, exp_valid);
    for (int k = 0; k < n; k++) begin
      check("pc",    bus.OUT_pc[k],      hp.pc + 31'(2 * rem[k]));
      check("instr", bus.OUT_instr[k],   hp.instr[rem[k]]);
      check("id",    bus.OUT_fetchID[k], hp.fetchID);
      check("fault", bus.OUT_fault[k],   hp.fault);
    end
    @(posedge clk);
    if (!rst || bus.IN_flush) begin
      mq.delete(); head_rem.delete(); head_loaded = 0;
    end else begin
      if (bus.IN_decReady && n > 0) begin
        repeat (n) void'(rem.pop_front());
        if (mq.size() > 0) begin
          if (rem.size() == 0) begin
            void'(mq.pop_front()); head_loaded = 0;
          end else begin
            head_rem = rem;
          end
        end
      end
      if (byp) begin
        if (rem.size() > 0) begin
          mq.push_back(np); head_rem = rem; head_loaded = 1;
        end
      end else if (push) begin
        mq.push_back(np);
      end
      if (mq.size() > 0 && !head_loaded) begin
        head_rem.delete();
        for (int s = 0; s < SLOTS; s++) if (mq[0].mask[s]) head_rem.push_back(s);
        head_loaded = 1;
      end
    end
    #1;
  endtask

  initial begin
    drive(0, '0, '0, 2'd0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();  // reset state: ready=1, count=0, no lanes

    // Four-slot packet drains two lanes per cycle.
    drive(1, 31'h80, 4'b1111, 2'd0, 0, 0); step();
    drive(0, '0, '0, 2'd0, 0, 1); #1;
    check("q33_v0",  bus.OUT_valid, 2'b11);
    check("q33_pc0", bus.OUT_pc[0], 31'h80);
    check("q33_pc1", bus.OUT_pc[1], 31'h82);
    step();
    check("q33_pc2", bus.OUT_pc[0], 31'h84);
    check("q33_pc3", bus.OUT_pc[1], 31'h86);
    step();
    check("q33_end", bus.OUT_valid, 2'b00);
    step();

    // Sparse mask; the second packet is never merged into the first.
    drive(1, 31'h200, 4'b1010, 2'd0, 0, 0); step();
    drive(1, 31'h300, 4'b0001, 2'd0, 0, 0); step();
    drive(0, '0, '0, 2'd0, 0, 1); #1;
    check("q34_v0",  bus.OUT_valid, 2'b11);
    check("q34_pc0", bus.OUT_pc[0], 31'h202);
    check("q34_pc1", bus.OUT_pc[1], 31'h206);
    step();
    check("q34_v1",  bus.OUT_valid, 2'b01);
    check("q34_pc2", bus.OUT_pc[0], 31'h300);
    step(); step();

    // Empty packet is dropped.
    drive(1, 31'h10, 4'b0000, 2'd0, 0, 0); step();
    check("drop_cnt", bus.OUT_count, 0);

    // Fill, refuse ninth, refuse push alongside pop.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 31'(i * 16), 4'b0001, 2'd0, 0, 0); step();
    end
    check("full_rdy", bus.OUT_ready, 1'b0);
    check("full_cnt", bus.OUT_count, DEPTH);
    drive(1, 31'h777, 4'b0001, 2'd0, 0, 0); step();
    drive(1, 31'h777, 4'b0001, 2'd0, 0, 1); step();
    check("popush_cnt", bus.OUT_count, DEPTH - 1);

    // Flush with a simultaneous push.
    drive(0, '0, '0, 2'd0, 1, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 31'(i * 8 + 1), 4'b0110, 2'd0, 0, 0); step();
    end
    drive(1, 31'h555, 4'b1111, 2'd0, 1, 1); step();
    drive(0, '0, '0, 2'd0, 0, 1); #1;
    check("flush_cnt", bus.OUT_count, 0);
    check("flush_v",   bus.OUT_valid, 2'b00);
    step();

    // Faulting packet becomes one zero pseudo-instruction.
    drive(1, 31'h40, 4'b1111, 2'd2, 0, 0); step();
    drive(0, '0, '0, 2'd0, 0, 1); #1;
    check("flt_v",     bus.OUT_valid, 2'b01);
    check("flt_instr", bus.OUT_instr[0], 32'h0);
    check("flt_code",  bus.OUT_fault[0], 2'd2);
    step();
    check("flt_pop", bus.OUT_valid, 2'b00);

`ifdef FQ_BYPASS_EN
    drive(1, 31'h90, 4'b0011, 2'd0, 0, 1); #1;
    check("byp_v", bus.OUT_valid, 2'b11);
    step();
    check("byp_cnt", bus.OUT_count, 0);
`endif

    // Reset mid-operation, also asserted together with flush and a push.
    for (int i = 0; i < 3; i++) begin
      drive(1, 31'(i + 3), 4'b1011, 2'd0, 0, 0); step();
    end
    drive(1, 31'h66, 4'b1111, 2'd0, 1, 1);
    rst = 1'b0; step(); rst = 1'b1;
    drive(0, '0, '0, 2'd0, 0, 0); step();

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 7), 31'($urandom), 4'($urandom),
            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 1) == 1));
      rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
